// File: rtl/disparity_search_ctrl_if.sv
// Handshake bundle between the disparity search controller and its neighbours:
// column requests, window fetches, SSD results and the winning disparity.
interface disparity_search_ctrl_if #(
  parameter int unsigned OFF_W = 5,
  parameter int unsigned X_W   = 9,
  parameter int unsigned SSD_W = 9
) ();
  logic             req_valid_in;
  logic [X_W-1:0]   req_x_in;
  logic             req_ready_out;
  logic             fetch_valid_out;
  logic [OFF_W-1:0] fetch_offset_out;
  logic             fetch_ready_in;
  logic             ssd_valid_in;
  logic [SSD_W-1:0] ssd_in;
  logic             disp_valid_out;
  logic [OFF_W-1:0] disp_out;
  logic [SSD_W-1:0] disp_cost_out;
  logic             disp_ready_in;
  logic             busy_out;
  logic             err_out;

  modport slave (
    input  req_valid_in, req_x_in, fetch_ready_in, ssd_valid_in, ssd_in, disp_ready_in,
    output req_ready_out, fetch_valid_out, fetch_offset_out, disp_valid_out, disp_out,
           disp_cost_out, busy_out, err_out
  );

  modport master (
    output req_valid_in, req_x_in, fetch_ready_in, ssd_valid_in, ssd_in, disp_ready_in,
    input  req_ready_out, fetch_valid_out, fetch_offset_out, disp_valid_out, disp_out,
           disp_cost_out, busy_out, err_out
  );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Per-column disparity sweep: issues one window fetch per candidate offset,
// folds in-order SSD results into a running minimum, presents the winner.
module disparity_search_ctrl #(
  parameter int unsigned MAX_OFFSET = 30,
  parameter int unsigned OFF_W      = 5,
  parameter int unsigned X_W        = 9,
  parameter int unsigned SSD_W      = 9
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  disparity_search_ctrl_if.slave  bus
);

  // One extra bit so the receive count can reach d_max+1 for any legal MAX_OFFSET.
  localparam int unsigned CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t           state, state_nxt;
  logic [OFF_W-1:0] issue_cnt, issue_nxt;
  logic [OFF_W-1:0] d_max, d_max_nxt;
  logic [OFF_W-1:0] best_d, best_d_nxt;
  logic [SSD_W-1:0] best_cost, best_cost_nxt;
  logic [CNT_W-1:0] rcv_cnt, rcv_nxt, rcv_end;
  logic             err_nxt;
  logic             collecting, accept;

  logic             req_ready_q, busy_q, err_q;
  logic             fetch_valid_q, disp_valid_q;
  logic [OFF_W-1:0] fetch_offset_q, disp_q;
  logic [SSD_W-1:0] disp_cost_q;

  // Next-state, counters and running minimum.
  always_comb begin
    state_nxt     = state;
    issue_nxt     = issue_cnt;
    d_max_nxt     = d_max;
    best_d_nxt    = best_d;
    best_cost_nxt = best_cost;
    rcv_nxt       = rcv_cnt;
    err_nxt       = err_q;
    rcv_end       = CNT_W'(d_max) + CNT_W'(1);
    collecting    = (state == ISSUE) || (state == DRAIN);
    accept        = bus.ssd_valid_in && collecting && (rcv_cnt != rcv_end);

    if (bus.ssd_valid_in && !accept) begin
      err_nxt = 1'b1;
    end
    // First result seeds the minimum; strict compare keeps the smaller d on ties.
    if (accept) begin
      rcv_nxt = rcv_cnt + CNT_W'(1);
      if ((rcv_cnt == '0) || (bus.ssd_in < best_cost)) begin
        best_cost_nxt = bus.ssd_in;
        best_d_nxt    = OFF_W'(rcv_cnt);
      end
    end

    case (state)
      IDLE: begin
        if (bus.req_valid_in && req_ready_q) begin
          d_max_nxt = (bus.req_x_in < X_W'(MAX_OFFSET)) ? OFF_W'(bus.req_x_in)
                                                        : OFF_W'(MAX_OFFSET);
          issue_nxt = '0;
          rcv_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (fetch_valid_q && bus.fetch_ready_in) begin
          issue_nxt = issue_cnt + OFF_W'(1);
          if (issue_cnt == d_max) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rcv_nxt == rcv_end) begin
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (disp_valid_q && bus.disp_ready_in) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      issue_cnt      <= '0;
      d_max          <= '0;
      best_d         <= '0;
      best_cost      <= '0;
      rcv_cnt        <= '0;
      req_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      fetch_valid_q  <= 1'b0;
      fetch_offset_q <= '0;
      disp_valid_q   <= 1'b0;
      disp_q         <= '0;
      disp_cost_q    <= '0;
    end else begin
      state          <= state_nxt;
      issue_cnt      <= issue_nxt;
      d_max          <= d_max_nxt;
      best_d         <= best_d_nxt;
      best_cost      <= best_cost_nxt;
      rcv_cnt        <= rcv_nxt;
      req_ready_q    <= (state_nxt == IDLE);
      busy_q         <= (state_nxt != IDLE);
      err_q          <= err_nxt;
      fetch_valid_q  <= (state_nxt == ISSUE);
      fetch_offset_q <= (state_nxt == ISSUE) ? issue_nxt : '0;
      disp_valid_q   <= (state_nxt == OUTPUT);
      if ((state_nxt == OUTPUT) && (state != OUTPUT)) begin
        disp_q      <= best_d_nxt;
        disp_cost_q <= best_cost_nxt;
      end
    end
  end

  assign bus.req_ready_out    = req_ready_q;
  assign bus.busy_out         = busy_q;
  assign bus.err_out          = err_q;
  assign bus.fetch_valid_out  = fetch_valid_q;
  assign bus.fetch_offset_out = fetch_offset_q;
  assign bus.disp_valid_out   = disp_valid_q;
  assign bus.disp_out         = disp_q;
  assign bus.disp_cost_out    = disp_cost_q;

endmodule
